// File: rtl/spi_log_pkg.sv
// ============================================================================
// spi_log_pkg : shared types and constants for the SPI log framer
// Revision    : 1.0
// ============================================================================
`default_nettype none

package spi_log_pkg;

    typedef enum logic [1:0] {
        MODE_RAW     = 2'd0,
        MODE_MONITOR = 2'd1,
        MODE_SUMMARY = 2'd2,
        MODE_OFF     = 2'd3
    } mode_e;

    localparam logic [2:0] LEN_RAW = 3'd1;
    localparam logic [2:0] LEN_MON = 3'd4;
    localparam logic [2:0] LEN_SUM = 3'd5;

    typedef enum logic [0:0] {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/log_fifo.sv
// ============================================================================
// log_fifo : synchronous byte FIFO, registered read, level output
// Revision : 1.0
// ============================================================================
`default_nettype none

module log_fifo #(
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [7:0]               wdata_i,
    input  logic                     pop_i,
    output logic [7:0]               rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    logic [7:0]  rdata_q;
    logic        w_do_push;
    logic        w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o   = (wptr_q == rptr_q);
    assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level_o   = wptr_q - rptr_q;
    assign rdata_o   = rdata_q;
    assign w_do_push = push_i & ~full_o;
    assign w_do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            rdata_q <= 8'h00;
        end else begin
            if (w_do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (w_do_pop) begin
                rdata_q <= mem_q[rptr_q[AW-1:0]];
                rptr_q  <= rptr_q + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_log_framer.sv
// ============================================================================
// spi_log_framer : frames SPI bytes into log records, buffers and drains them
// Revision       : 1.0
// ============================================================================
`default_nettype none

module spi_log_framer
    import spi_log_pkg::*;
#(
    parameter int FIFO_DEPTH = 512,
    parameter int MAX_BYTES  = 4,
    parameter int DROP_W     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    mode,
    input  logic                          spi_cs,
    input  logic                          spi_rx_strobe,
    input  logic                          spi_rx_cmd,
    input  logic [7:0]                    spi_rx_data,
    input  logic [7:0]                    spi_rx_miso,
    input  logic                          txd_ready,
    output logic [7:0]                    txd,
    output logic                          txd_strobe,
    output logic [DROP_W-1:0]             dropped,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    mode_e            active_mode_q;
    logic [15:0]      byte_idx_q;
    logic             cs_q;
    logic             sum_seen_q;
    logic [7:0]       sum_cmd_q;
    logic [7:0]       sum_a2_q;
    logic [7:0]       sum_a1_q;
    logic [7:0]       sum_a0_q;
    logic [7:0]       sum_len_q;
    logic [DROP_W-1:0] dropped_q;

    ser_state_e       ser_state_q;
    logic [4:0][7:0]  rec_q;
    logic [2:0]       rec_len_q;
    logic [2:0]       ser_idx_q;

    logic             hv_q;
    logic [7:0]       txd_q;

    logic             w_cmd_stb;
    mode_e            w_eff_mode;
    logic [15:0]      w_cur_idx;
    logic             w_cs_rise;
    logic             w_due;
    logic [2:0]       w_len;
    logic [4:0][7:0]  w_rec;
    logic [LW-1:0]    w_fifo_level;
    logic [LW-1:0]    w_level;
    logic [LW-1:0]    w_free;
    logic             w_accept;
    logic             w_drop;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic [7:0]       w_head;
    logic             w_strobe;

    assign w_cmd_stb  = spi_rx_strobe & spi_rx_cmd;
    assign w_eff_mode = w_cmd_stb ? mode_e'(mode) : active_mode_q;
    assign w_cur_idx  = w_cmd_stb ? 16'd0 : byte_idx_q;
    assign w_cs_rise  = spi_cs & ~cs_q;

    always_comb begin
        w_due = 1'b0;
        w_len = 3'd0;
        w_rec = '0;
        if (w_cs_rise && sum_seen_q) begin
            w_due    = 1'b1;
            w_len    = LEN_SUM;
            w_rec[0] = sum_cmd_q;
            w_rec[1] = sum_a2_q;
            w_rec[2] = sum_a1_q;
            w_rec[3] = sum_a0_q;
            w_rec[4] = sum_len_q;
        end else if (spi_rx_strobe) begin
            case (w_eff_mode)
                MODE_RAW: begin
                    if (w_cur_idx < 16'(MAX_BYTES)) begin
                        w_due    = 1'b1;
                        w_len    = LEN_RAW;
                        w_rec[0] = spi_rx_data;
                    end
                end
                MODE_MONITOR: begin
                    w_due    = 1'b1;
                    w_len    = LEN_MON;
                    w_rec[0] = w_cur_idx[15:8];
                    w_rec[1] = w_cur_idx[7:0];
                    w_rec[2] = spi_rx_data;
                    w_rec[3] = spi_rx_miso;
                end
                default: ;
            endcase
        end
    end

    // The prefetched head byte still counts as buffered for space accounting.
    assign w_level  = w_fifo_level + LW'(hv_q);
    assign w_free   = LW'(FIFO_DEPTH) - w_level;
    assign w_accept = w_due && (ser_state_q == SER_IDLE) && (w_free >= LW'(w_len));
    assign w_drop   = w_due & ~w_accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            active_mode_q <= MODE_OFF;
            byte_idx_q    <= 16'd0;
            cs_q          <= 1'b1;
            sum_seen_q    <= 1'b0;
            sum_cmd_q     <= 8'h00;
            sum_a2_q      <= 8'h00;
            sum_a1_q      <= 8'h00;
            sum_a0_q      <= 8'h00;
            sum_len_q     <= 8'h00;
            dropped_q     <= '0;
        end else begin
            cs_q <= spi_cs;
            if (w_cs_rise) begin
                sum_seen_q <= 1'b0;
            end
            if (spi_rx_strobe) begin
                byte_idx_q <= (w_cur_idx == 16'hFFFF) ? w_cur_idx : w_cur_idx + 16'd1;
                if (spi_rx_cmd) begin
                    active_mode_q <= mode_e'(mode);
                    sum_seen_q    <= (mode_e'(mode) == MODE_SUMMARY);
                    sum_cmd_q     <= spi_rx_data;
                    sum_a2_q      <= 8'h00;
                    sum_a1_q      <= 8'h00;
                    sum_a0_q      <= 8'h00;
                    sum_len_q     <= 8'h00;
                end else if (active_mode_q == MODE_SUMMARY) begin
                    case (byte_idx_q)
                        16'd1:   sum_a2_q  <= spi_rx_data;
                        16'd2:   sum_a1_q  <= spi_rx_data;
                        16'd3:   sum_a0_q  <= spi_rx_data;
                        default: sum_len_q <= sat_inc8(sum_len_q);
                    endcase
                end
            end
            if (w_drop && (dropped_q != '1)) begin
                dropped_q <= dropped_q + DROP_W'(1);
            end
        end
    end

    // Serialiser: a record is only accepted whole, then written one byte per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ser_state_q <= SER_IDLE;
            rec_q       <= '0;
            rec_len_q   <= 3'd0;
            ser_idx_q   <= 3'd0;
        end else begin
            case (ser_state_q)
                SER_IDLE: begin
                    if (w_accept) begin
                        rec_q       <= w_rec;
                        rec_len_q   <= w_len;
                        ser_idx_q   <= 3'd0;
                        ser_state_q <= SER_SEND;
                    end
                end
                SER_SEND: begin
                    ser_idx_q <= ser_idx_q + 3'd1;
                    if (ser_idx_q == rec_len_q - 3'd1) begin
                        ser_state_q <= SER_IDLE;
                    end
                end
                default: ser_state_q <= SER_IDLE;
            endcase
        end
    end

    assign w_push = (ser_state_q == SER_SEND) & ~w_full;

    log_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_push),
        .wdata_i (rec_q[ser_idx_q]),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .empty_o (w_empty),
        .full_o  (w_full),
        .level_o (w_fifo_level)
    );

    // Head register refills on the same cycle it is consumed, so drain runs back-to-back.
    assign w_strobe = hv_q & txd_ready;
    assign w_pop    = ~w_empty & (~hv_q | w_strobe);

    always_ff @(posedge clk) begin
        if (reset) begin
            hv_q  <= 1'b0;
            txd_q <= 8'h00;
        end else begin
            if (w_pop) begin
                hv_q <= 1'b1;
            end else if (w_strobe) begin
                hv_q <= 1'b0;
            end
            if (w_strobe) begin
                txd_q <= w_head;
            end
        end
    end

    assign txd        = w_strobe ? w_head : txd_q;
    assign txd_strobe = w_strobe;
    assign dropped    = dropped_q;
    assign fifo_level = w_level;

endmodule

`default_nettype wire

// File: tb/tb_spi_log_framer.sv
// ============================================================================
// tb_spi_log_framer : scoreboard bench for spi_log_framer (FIFO_DEPTH=8)
// Revision          : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_log_framer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic        spi_cs;
    logic        spi_rx_strobe;
    logic        spi_rx_cmd;
    logic [7:0]  spi_rx_data;
    logic [7:0]  spi_rx_miso;
    logic        txd_ready;
    logic [7:0]  txd;
    logic        txd_strobe;
    logic [15:0] dropped;
    logic [3:0]  fifo_level;

    logic [7:0]  sb[$];
    logic [7:0]  obs[$];
    int          errors = 0;
    int          checks = 0;
    int          strobe_low = 0;

    always #5 clk = ~clk;

    spi_log_framer #(
        .FIFO_DEPTH (8),
        .MAX_BYTES  (4),
        .DROP_W     (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mode          (mode),
        .spi_cs        (spi_cs),
        .spi_rx_strobe (spi_rx_strobe),
        .spi_rx_cmd    (spi_rx_cmd),
        .spi_rx_data   (spi_rx_data),
        .spi_rx_miso   (spi_rx_miso),
        .txd_ready     (txd_ready),
        .txd           (txd),
        .txd_strobe    (txd_strobe),
        .dropped       (dropped),
        .fifo_level    (fifo_level)
    );

    always @(negedge clk) begin
        if (txd_strobe) begin
            obs.push_back(txd);
            if (!txd_ready) strobe_low++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_byte(input logic c, input logic [7:0] mosi, input logic [7:0] miso);
        spi_rx_cmd    = c;
        spi_rx_data   = mosi;
        spi_rx_miso   = miso;
        spi_rx_strobe = 1'b1;
        tick(1);
        spi_rx_strobe = 1'b0;
        spi_rx_cmd    = 1'b0;
        tick(9);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (obs.size() < sb.size() && n < budget) begin
            tick(1);
            n++;
        end
        tick(4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        checks++; if (txd !== 8'h00) begin errors++; $display("FAIL reset_txd got=%h want=00", txd); end
        checks++; if (txd_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got=%b want=0", txd_strobe); end
        checks++; if (dropped !== 16'd0) begin errors++; $display("FAIL reset_dropped got=%0d want=0", dropped); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
    endtask

    task automatic test_raw();
        logic [7:0] tx [6] = '{8'h03, 8'h00, 8'h10, 8'h00, 8'hAA, 8'hBB};
        logic [7:0] e;
        logic [7:0] g;
        sb.delete(); obs.delete();
        mode = 2'd0; txd_ready = 1'b1; spi_cs = 1'b0;
        tick(2);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) sb.push_back(tx[i]);
            spi_byte(i == 0, tx[i], 8'h00);
        end
        spi_cs = 1'b1;
        wait_drain(100);
        checks++; if (obs.size() != sb.size()) begin errors++; $display("FAIL raw_count got=%0d want=%0d", obs.size(), sb.size()); end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            g = (obs.size() > 0) ? obs.pop_front() : 8'hxx;
            checks++; if (g !== e) begin errors++; $display("FAIL raw_byte got=%h want=%h", g, e); end
        end
        checks++; if (dropped !== 16'd0) begin errors++; $display("FAIL raw_dropped got=%0d want=0", dropped); end
    endtask

    task automatic test_monitor();
        logic [7:0] mo [3] = '{8'h0B, 8'h00, 8'h20};
        logic [7:0] mi [3] = '{8'hFF, 8'hFF, 8'h5A};
        logic [7:0] e;
        logic [7:0] g;
        sb.delete(); obs.delete();
        mode = 2'd1; txd_ready = 1'b1; spi_cs = 1'b0;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            sb.push_back(8'h00); sb.push_back(8'(i)); sb.push_back(mo[i]); sb.push_back(mi[i]);
            spi_byte(i == 0, mo[i], mi[i]);
            mode = 2'd0;   // mid-transaction change must not take effect
        end
        spi_cs = 1'b1;
        wait_drain(200);
        checks++; if (obs.size() != sb.size()) begin errors++; $display("FAIL mon_count got=%0d want=%0d", obs.size(), sb.size()); end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            g = (obs.size() > 0) ? obs.pop_front() : 8'hxx;
            checks++; if (g !== e) begin errors++; $display("FAIL mon_byte got=%h want=%h", g, e); end
        end
    endtask

    task automatic test_summary();
        logic [7:0] e;
        logic [7:0] g;
        sb.delete(); obs.delete();
        mode = 2'd2; txd_ready = 1'b1; spi_cs = 1'b0;
        tick(2);
        spi_byte(1'b1, 8'h03, 8'h00);
        spi_byte(1'b0, 8'h12, 8'h00);
        spi_byte(1'b0, 8'h34, 8'h00);
        spi_byte(1'b0, 8'h56, 8'h00);
        for (int i = 0; i < 300; i++) spi_byte(1'b0, 8'(i), 8'h00);
        sb.push_back(8'h03); sb.push_back(8'h12); sb.push_back(8'h34); sb.push_back(8'h56); sb.push_back(8'hFF);
        spi_cs = 1'b1;
        tick(3);
        spi_cs = 1'b0;
        tick(2);
        spi_byte(1'b1, 8'h05, 8'h00);
        for (int i = 0; i < 4; i++) sb.push_back(i == 0 ? 8'h05 : 8'h00);
        sb.push_back(8'h00);
        spi_cs = 1'b1;
        wait_drain(100);
        // A second rise with no new command must stay silent.
        spi_cs = 1'b0; tick(3); spi_cs = 1'b1; tick(20);
        checks++; if (obs.size() != sb.size()) begin errors++; $display("FAIL sum_count got=%0d want=%0d", obs.size(), sb.size()); end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            g = (obs.size() > 0) ? obs.pop_front() : 8'hxx;
            checks++; if (g !== e) begin errors++; $display("FAIL sum_byte got=%h want=%h", g, e); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] e;
        logic [7:0] g;
        sb.delete(); obs.delete();
        mode = 2'd1; txd_ready = 1'b0; spi_cs = 1'b0;
        tick(2);
        spi_byte(1'b1, 8'h0B, 8'hFF);
        spi_byte(1'b0, 8'h11, 8'h22);
        spi_byte(1'b0, 8'h33, 8'h44);
        spi_cs = 1'b1;
        tick(10);
        sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h0B); sb.push_back(8'hFF);
        sb.push_back(8'h00); sb.push_back(8'h01); sb.push_back(8'h11); sb.push_back(8'h22);
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level got=%0d want=8", fifo_level); end
        checks++; if (dropped !== 16'd1) begin errors++; $display("FAIL ovf_dropped got=%0d want=1", dropped); end
        checks++; if (obs.size() != 0) begin errors++; $display("FAIL ovf_early got=%0d want=0", obs.size()); end
        txd_ready = 1'b1;
        wait_drain(60);
        tick(20);
        checks++; if (obs.size() != sb.size()) begin errors++; $display("FAIL ovf_count got=%0d want=%0d", obs.size(), sb.size()); end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            g = (obs.size() > 0) ? obs.pop_front() : 8'hxx;
            checks++; if (g !== e) begin errors++; $display("FAIL ovf_byte got=%h want=%h", g, e); end
        end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL ovf_level_end got=%0d want=0", fifo_level); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        logic [7:0] g;
        int n;
        sb.delete(); obs.delete();
        strobe_low = 0;
        mode = 2'd0; txd_ready = 1'b0; spi_cs = 1'b0;
        tick(2);
        spi_byte(1'b1, 8'hA1, 8'h00); spi_byte(1'b0, 8'hA2, 8'h00);
        spi_byte(1'b0, 8'hA3, 8'h00); spi_byte(1'b0, 8'hA4, 8'h00);
        spi_cs = 1'b1; tick(3); spi_cs = 1'b0; tick(2);
        spi_byte(1'b1, 8'hB1, 8'h00); spi_byte(1'b0, 8'hB2, 8'h00);
        spi_cs = 1'b1;
        tick(5);
        sb.push_back(8'hA1); sb.push_back(8'hA2); sb.push_back(8'hA3);
        sb.push_back(8'hA4); sb.push_back(8'hB1); sb.push_back(8'hB2);
        checks++; if (fifo_level !== 4'd6) begin errors++; $display("FAIL b2b_level got=%0d want=6", fifo_level); end
        n = 0;
        while (n < 40) begin
            txd_ready = ~txd_ready;
            tick(1);
            n++;
        end
        txd_ready = 1'b1;
        tick(4);
        checks++; if (obs.size() != sb.size()) begin errors++; $display("FAIL b2b_count got=%0d want=%0d", obs.size(), sb.size()); end
        checks++; if (strobe_low != 0) begin errors++; $display("FAIL b2b_strobe_low got=%0d want=0", strobe_low); end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            g = (obs.size() > 0) ? obs.pop_front() : 8'hxx;
            checks++; if (g !== e) begin errors++; $display("FAIL b2b_byte got=%h want=%h", g, e); end
        end
    endtask

    task automatic test_reset_mid();
        sb.delete(); obs.delete();
        mode = 2'd2; txd_ready = 1'b1; spi_cs = 1'b0;
        tick(2);
        spi_byte(1'b1, 8'h07, 8'h00);
        spi_byte(1'b0, 8'h11, 8'h00);
        spi_byte(1'b0, 8'h22, 8'h00);
        reset = 1'b1; tick(2); reset = 1'b0; tick(2);
        spi_cs = 1'b1;
        tick(20);
        checks++; if (obs.size() != 0) begin errors++; $display("FAIL rstmid_out got=%0d want=0", obs.size()); end
        checks++; if (dropped !== 16'd0) begin errors++; $display("FAIL rstmid_dropped got=%0d want=0", dropped); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL rstmid_level got=%0d want=0", fifo_level); end
    endtask

    initial begin
        reset = 1'b1; mode = 2'd3; spi_cs = 1'b1; spi_rx_strobe = 1'b0; spi_rx_cmd = 1'b0;
        spi_rx_data = 8'h00; spi_rx_miso = 8'h00; txd_ready = 1'b0;
        tick(1);
        test_reset();
        test_raw();
        test_monitor();
        test_summary();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_log_framer.md
Name: spi_log_framer

Overview:
Parametrised SPI bus logger that converts the byte stream from spi_device (rx_strobe/cmd/data/miso) into framed log records. It buffers the records in an internal FIFO and drains them to the serial transmit arbiter (USB serial or UART) under a ready/strobe handshake. It replaces the ad-hoc per-byte logging in the top level and adds three selectable modes, whole-record atomic commit and drop accounting.

Parameters:
FIFO_DEPTH, 512, log FIFO depth in bytes; must be a power of two and at least 8.
MAX_BYTES, 4, bytes logged per transaction in RAW mode, including the command byte; range 1..255.
DROP_W, 16, width of the dropped-record counter.

Ports:
clk  input  1  system clock (132 MHz domain)
reset  input  1  synchronous, active-high reset
mode  input  2  0=RAW, 1=MONITOR, 2=SUMMARY, 3=OFF
spi_cs  input  1  active-low chip select, already synchronous to clk
spi_rx_strobe  input  1  one-cycle pulse per received byte
spi_rx_cmd  input  1  qualifies strobe: first byte of the transaction
spi_rx_data  input  8  MOSI byte
spi_rx_miso  input  8  MISO byte sampled during the same byte
txd_ready  input  1  downstream can accept a byte this cycle
txd  output  8  log byte
txd_strobe  output  1  one-cycle pulse: txd valid and consumed
dropped  output  DROP_W  records dropped since reset, saturating
fifo_level  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered

Behaviour:
- Reset: FIFO flushed; txd=0, txd_strobe=0, dropped=0, fifo_level=0; assembler idle; active mode=OFF until the next cmd byte.
- Mode latch:
  - mode is sampled only on spi_rx_strobe with spi_rx_cmd=1.
  - Changes mid-transaction take effect at the next command.
- Record assembly:
  - Each record is built in a 5-byte staging register and serialised into the FIFO at one byte per cycle.
  - Before the first write, free space (FIFO_DEPTH - fifo_level) must be >= record length. Otherwise the whole record is discarded and dropped increments, saturating at all-ones. Partial records never enter the FIFO.
- RAW (len 1 per byte):
  - Each strobe with byte index < MAX_BYTES writes spi_rx_data. The index resets to 0 on the cmd byte.
  - Bytes beyond MAX_BYTES are ignored and not counted as drops.
- MONITOR (len 4 per byte):
  - Each strobe emits {idx[15:8], idx[7:0], mosi, miso}.
  - idx=0 on the cmd byte, then increments per byte, saturating at 0xFFFF.
- SUMMARY (len 5 per transaction):
  - cmd and the next three bytes are captured as addr[23:16], [15:8], [7:0].
  - len counts bytes after the address, saturating at 255.
  - On the spi_cs rising edge (registered previous value), emit {cmd, a2, a1, a0, len}. Address bytes not yet received read as 0x00.
  - A cs rise with no cmd seen since the last rise emits nothing.
- OFF: nothing is captured.
- Busy collision:
  - The serialiser needs up to 5 cycles. Upstream guarantees >= 8 clk between strobes.
  - If a new record is due while the serialiser is busy, the new record is dropped and counted. The in-flight record completes.
- Drain:
  - When the FIFO is non-empty and txd_ready=1, pulse txd_strobe for one cycle with txd = FIFO head. The byte is popped that cycle.
  - Maximum one byte per cycle. Back-to-back strobes are allowed while txd_ready stays high.
  - Latency from the first FIFO write to txd_strobe is 2 cycles (registered read).
  - txd holds its last value when strobe=0.
- Simultaneous push and pop: fifo_level is unchanged. Full and empty are derived from a pointer MSB-extended compare.
- Reset mid-record: the record is abandoned and nothing is emitted.

Decomposition:
- Package spi_log_pkg:
  - mode constants MODE_RAW/MONITOR/SUMMARY/OFF
  - record lengths LEN_RAW=1, LEN_MON=4, LEN_SUM=5
- Sub-module log_fifo: synchronous byte FIFO with registered read, level output and push/pop on the same cycle. It is reused by the UART block.

Test Plan:
- RAW, MAX_BYTES=4, transaction 03 00 10 00 AA BB, txd_ready=1 -> txd sequence 03 00 10 00; dropped=0.
- MONITOR, bytes (mosi/miso) 0B/FF, 00/FF, 20/5A -> 00 00 0B FF 00 01 00 FF 00 02 20 5A.
- SUMMARY, 03 12 34 56 followed by 300 data bytes, then cs high -> 03 12 34 56 FF. A second transaction of 05 only, then cs high -> 05 00 00 00 00.
- Overflow: FIFO_DEPTH=8, txd_ready=0, MONITOR with 3 bytes -> fifo_level=8, dropped=1. Raising txd_ready drains exactly 8 bytes with no partial third record.
- Drain handshake: toggle txd_ready every cycle with 6 bytes queued -> exactly 6 strobes, in order, none while ready=0.
- Reset asserted mid-SUMMARY transaction, then cs rise -> no output, dropped=0, fifo_level=0.
